// File: rtl/uart_mmio.sv
// uart_mmio
// ---------
// Memory-mapped I/O responder for the 0x8xxx_xxxx region of the RISC-V core.
// It handles loads and stores to a small register file. It buffers received
// UART bytes in a FIFO, holds one transmit byte for the UART transmitter, and
// keeps the cycle and retired-instruction counters.
//
// Register map (offset = Addr[7:0]; Addr[27:8] are ignored, so aliases exist):
//   0x00 R  status   {28'b0, rx_full, 1'b0, rx_valid, tx_ready}
//   0x04 R  rx data  {24'b0, fifo head}; the read pops the FIFO (0 if empty)
//   0x08 W  tx data  Din[7:0]; needs Uart_trans[0]
//   0x10 R  cycle_count
//   0x14 R  instr_count
//   0x18 W  clear both counters
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   Addr, Din     load/store address and lane-aligned store data
//   Uart_trans    byte write mask; any bit set means a store
//   Uart_recv     load strobe
//   Inst_retire   one pulse per committed instruction
//   Dout          registered load data, valid one cycle after Uart_recv
//   TxData/TxDataValid/TxDataReady   transmit byte handshake
//   RxData/RxDataValid/RxDataReady   receive byte handshake
module uart_mmio #(
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Addr,
  input  logic [31:0] Din,
  input  logic [3:0]  Uart_trans,
  input  logic        Uart_recv,
  input  logic        Inst_retire,
  output logic [31:0] Dout,
  output logic [7:0]  TxData,
  output logic        TxDataValid,
  input  logic        TxDataReady,
  input  logic [7:0]  RxData,
  input  logic        RxDataValid,
  output logic        RxDataReady
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(RX_DEPTH);

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_CYCLE  = 8'h10;
  localparam logic [7:0] OFF_INSTR  = 8'h14;
  localparam logic [7:0] OFF_CLEAR  = 8'h18;

  logic [7:0]    rx_mem [RX_DEPTH];
  logic [AW-1:0] rx_rd_ptr;
  logic [AW-1:0] rx_wr_ptr;
  logic [CW-1:0] rx_count;
  logic [31:0]   cycle_count;
  logic [31:0]   instr_count;

  logic [7:0]  offset;
  logic        is_write;
  logic        rx_full;
  logic        rx_valid;
  logic        rx_push;
  logic        rx_pop;
  logic        tx_take;
  logic        tx_drain;
  logic        cnt_clear;
  logic [7:0]  rx_head;
  logic [31:0] status_word;

  // Upper address and store-data bits play no part in this block.
  logic unused_bits;
  assign unused_bits = ^{Addr[31:8], Din[31:8]};

  assign offset   = Addr[7:0];
  assign is_write = |Uart_trans;
  assign rx_full  = (rx_count == FULL_COUNT);
  assign rx_valid = (rx_count != '0);
  assign rx_head  = rx_mem[rx_rd_ptr];

  assign RxDataReady = !rx_full;

  assign rx_push   = RxDataValid && RxDataReady;
  // A read of an empty FIFO returns 0 and leaves the pointers alone.
  assign rx_pop    = Uart_recv && (offset == OFF_RXDATA) && rx_valid;
  assign tx_drain  = TxDataValid && TxDataReady;
  // A new byte is taken if the holding register is empty or is being drained
  // on this very edge, so the transmitter can stream one byte per cycle.
  assign tx_take   = is_write && (offset == OFF_TXDATA) && Uart_trans[0] &&
                     (!TxDataValid || TxDataReady);
  assign cnt_clear = is_write && (offset == OFF_CLEAR);

  assign status_word = {28'b0, rx_full, 1'b0, rx_valid, !TxDataValid};

  // Load data path: everything is sampled from pre-edge state, so status
  // never shows a push or pop that happens on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      Dout <= '0;
    end else if (Uart_recv) begin
      case (offset)
        OFF_STATUS: Dout <= status_word;
        OFF_RXDATA: Dout <= rx_valid ? {24'b0, rx_head} : 32'b0;
        OFF_CYCLE:  Dout <= cycle_count;
        OFF_INSTR:  Dout <= instr_count;
        default:    Dout <= '0;
      endcase
    end
  end

  // Transmit holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      TxData      <= '0;
      TxDataValid <= 1'b0;
    end else if (tx_take) begin
      TxData      <= Din[7:0];
      TxDataValid <= 1'b1;
    end else if (tx_drain) begin
      TxDataValid <= 1'b0;
    end
  end

  // FIFO storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wr_ptr] <= RxData;
    end
  end

  // FIFO pointers and occupancy. A simultaneous push and pop moves both
  // pointers and leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) begin
        rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      end
      if (rx_pop) begin
        rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CNT_ONE;
        2'b01:   rx_count <= rx_count - CNT_ONE;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Performance counters; a clear store wins over the increment on its edge.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (Inst_retire) begin
        instr_count <= instr_count + 32'd1;
      end
    end
  end

endmodule
